// File: rtl/decoder_stream_arbiter_pkg.sv
// Shared types and helpers for the decoder stream arbiter and its round-robin picker.
`default_nettype none

package decoder_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // $clog2 that never returns 0, so a one-entry range still gets a 1-bit field
  function automatic int grant_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_stream_arbiter_picker.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping upward.
`default_nettype none

module rr_priority_picker
  import decoder_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic         found,
  output logic [W-1:0] winner
);

  logic [W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/decoder_stream_arbiter.sv
// Round-robin arbiter multiplexing N AXI-stream sources onto the Decoder input, tagging beats with dest.
`default_nettype none

module decoder_stream_arbiter
  import decoder_arbiter_pkg::*;
#(
  parameter int N_INPUTS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEST_WIDTH   = 8,
  parameter int BURST_LENGTH = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  data_in_data,
  input  logic [N_INPUTS-1:0]                  data_in_tlast,
  input  logic [N_INPUTS-1:0]                  data_in_valid,
  output logic [N_INPUTS-1:0]                  data_in_ready,
  output logic [DATA_WIDTH-1:0]                data_out_data,
  output logic [DEST_WIDTH-1:0]                data_out_dest,
  output logic                                 data_out_tlast,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready,
  input  logic [N_INPUTS-1:0]                  enable_mask,
  output logic [grant_width(N_INPUTS)-1:0]     grant_id,
  output logic                                 busy
);

  localparam int GW = grant_width(N_INPUTS);
  localparam int BW = grant_width(BURST_LENGTH + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'((BURST_LENGTH > 0) ? BURST_LENGTH - 1 : 0);

  arb_state_t    state, state_next;
  logic [GW-1:0] last_grant, last_grant_next, grant_next, winner;
  logic [BW-1:0] beat_cnt, beat_next;
  logic          found, handshake, rel_now;

  rr_priority_picker #(
    .N (N_INPUTS),
    .W (GW)
  ) u_picker (
    .req        (data_in_valid & enable_mask),
    .last_grant (last_grant),
    .found      (found),
    .winner     (winner)
  );

  // Data path is a pure mux while granted; everything is forced low in IDLE
  always_comb begin
    data_out_valid = 1'b0;
    data_out_data  = '0;
    data_out_tlast = 1'b0;
    data_out_dest  = '0;
    data_in_ready  = '0;
    if (state == ARB_GRANTED) begin
      data_out_valid          = data_in_valid[grant_id];
      data_out_data           = data_in_data[grant_id];
      data_out_tlast          = data_in_tlast[grant_id];
      data_out_dest           = DEST_WIDTH'(grant_id);
      data_in_ready[grant_id] = data_out_ready;
    end
  end

  assign handshake = (state == ARB_GRANTED) && data_out_valid && data_out_ready;
  assign rel_now   = handshake &&
                     (data_out_tlast || ((BURST_LENGTH != 0) && (beat_cnt == BURST_LAST)));

  always_comb begin
    state_next      = state;
    grant_next      = grant_id;
    last_grant_next = last_grant;
    beat_next       = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_next = ARB_GRANTED;
          grant_next = winner;
          beat_next  = '0;
        end
      end
      ARB_GRANTED: begin
        if (rel_now) begin
          state_next      = ARB_IDLE;
          last_grant_next = grant_id;
          beat_next       = '0;
        end else if (handshake && (BURST_LENGTH != 0)) begin
          beat_next = beat_cnt + BW'(1);
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // last_grant resets to the top index so input 0 is first in line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_grant <= GW'(N_INPUTS - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_next;
      beat_cnt   <= beat_next;
      busy       <= (state_next == ARB_GRANTED);
    end
  end

endmodule

`default_nettype wire

// File: doc/decoder_stream_arbiter.md
# decoder_stream_arbiter

Round-robin arbiter that shares one Decoder stream input among `N_INPUTS` upstream AXI-stream sources. It sits directly in front of the Decoder `data_in` port and grants one source at a time, with packet (`tlast`) or fixed-burst granularity. It tags each forwarded beat with the source index on `dest` so downstream logic can demultiplex.

## Interface
- `N_INPUTS`, 4: number of requesting streams, 2..16.
- `DATA_WIDTH`, 32: width of `data` on all streams.
- `DEST_WIDTH`, 8: width of `dest` on all streams; must be ≥ `$clog2(N_INPUTS)`.
- `BURST_LENGTH`, 0: beats per grant before forced release; 0 means release on `tlast` only.

- `clock`, in, 1: single clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `data_in[N_INPUTS]`, axi_stream.slave, `DATA_WIDTH`: requesting streams; uses `data`, `tlast`, `valid`, `ready`.
- `data_out`, axi_stream.master, `DATA_WIDTH`: feeds Decoder `data_in`; `dest` carries the granted index, zero-extended.
- `enable_mask`, in, `N_INPUTS`: bit i = 1 lets input i compete; sampled only at arbitration.
- `grant_id`, out, `$clog2(N_INPUTS)`: index of the current or last grant.
- `busy`, out, 1: high while a grant is held.

## Operation
- **FSM states:** IDLE, GRANTED.
- **IDLE**
  - `data_out.valid` = 0; all `data_in[i].ready` = 0.
  - Candidates are the inputs with `data_in[i].valid & enable_mask[i]`.
  - The winner is the first candidate strictly after `last_grant`, searching upward with wrap (`N_INPUTS-1` wraps to 0).
  - If any candidate exists, register `grant_id` = winner, clear `beat_cnt`, and go to GRANTED. Otherwise stay in IDLE.
- **GRANTED**
  - Combinational pass-through from the selected input: `data_out.valid/data/tlast` = `data_in[grant_id]`, and `data_in[grant_id].ready` = `data_out.ready`.
  - Non-granted `ready` stays 0.
  - `data_out.dest` = `grant_id`.
  - On each handshake (`valid & ready`), `beat_cnt` increments.
  - Release, i.e. return to IDLE and set `last_grant` = `grant_id`, on the handshake where:
    - `tlast` = 1, or
    - `BURST_LENGTH` ≠ 0 and `beat_cnt` = `BURST_LENGTH-1`.
  - Both conditions on the same beat cause a single release.
- **beat_cnt**
  - Width `$clog2(BURST_LENGTH+1)`, minimum 1.
  - Not used when `BURST_LENGTH` = 0, apart from being held at 0.
- **Enable mask:**
  - Clearing the granted bit mid-grant does not abort the grant; the packet completes.
  - Setting a bit has no effect until the next IDLE cycle.
- **Stalls:**
  - A granted source dropping `valid` mid-packet holds the grant indefinitely; there is no timeout.
  - Downstream `ready` = 0 holds the state unchanged.
- **Reset (asynchronous, any state):**
  - State → IDLE, `last_grant` → `N_INPUTS-1` (so input 0 wins first), `grant_id` → 0, `beat_cnt` → 0.
  - A packet in flight is truncated with no `tlast`; upstream sources are responsible for recovery.

## Timing
- **Reset values:**
  - `data_out.valid` = 0, `data_out.tlast` = 0, `data_out.data` = 0, `data_out.dest` = 0.
  - All `data_in[i].ready` = 0, `grant_id` = 0, `busy` = 0.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at cycle N appears on `data_out` at cycle N+1.
- **Data latency:** 0 cycles while GRANTED (combinational); no registers in the data path.
- **Bubbles:** at least one idle cycle between consecutive grants, including re-grant to the same source.
- **`busy`:** registered; equals (state == GRANTED).

## Structure
- **Package `decoder_arbiter_pkg`:** the state enum (`ARB_IDLE`, `ARB_GRANTED`) and the `grant_width(N)` helper (`$clog2` with a minimum of 1).
- **Sub-module `rr_priority_picker`:**
  - Purely combinational.
  - Inputs: the request vector and `last_grant`.
  - Outputs: `found` and `winner` index.
  - Reusable by other shared-resource arbiters in the design.

## Test plan
- **Single source:** `N_INPUTS` = 4, only input 2 valid with a 3-beat packet. Expect `grant_id` = 2 one cycle after valid, 3 beats out with `dest` = 2 and `tlast` on beat 3, then `busy` = 0.
- **Fairness:** all four inputs continuously sending 1-beat packets. Expect grant order 0,1,2,3,0,…, one bubble between grants, and every `dest` matching its source.
- **Burst limit:** `BURST_LENGTH` = 4, input 1 sends a 10-beat packet while input 3 is requesting. Expect 4 beats from input 1, then 4 from input 3 (its packet permitting), then input 1 resumes.
- **Mask and backpressure:**
  - With `enable_mask` = 4'b1010, inputs 0 and 2 are never granted.
  - Clearing bit 1 mid-packet still lets input 1 finish to `tlast`.
  - Holding `data_out.ready` = 0 for 5 cycles freezes data, with no beat lost or duplicated.
- **Reset mid-packet:** assert `reset` low during beat 2 of 4. Expect all outputs at reset values asynchronously; after release, input 0 wins first when multiple inputs request.
